// File: rtl/dtc_lane_distrib_if.sv
// Word-input handshake bundle for dtc_lane_distrib: DCS-side word, lane select
// and valid/ready pair.
interface dtc_lane_distrib_if #(
    parameter int DW = 16
);
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [5:0]    dtc_wr_sel;
    logic          auto_inc;

    modport master (
        output din, din_valid, dtc_wr_sel, auto_inc,
        input  din_ready
    );

    modport slave (
        input  din, din_valid, dtc_wr_sel, auto_inc,
        output din_ready
    );
endinterface

// File: rtl/dtc_lane_distrib.sv
// Steers DCS words into NLANES registered lane slices with a per-lane write strobe.
// Optional build macro DTC_BCAST_EN: explicit select 63 broadcasts to every lane.
module dtc_lane_distrib #(
    parameter int NLANES  = 40,
    parameter int DW      = 16,
    parameter int STB_LEN = 2
) (
    input  logic                   dcsclk,
    input  logic                   reset,
    dtc_lane_distrib_if.slave      s_in,
    input  logic                   ptr_clr,
    output logic [NLANES*DW-1:0]   dtc_din,
    output logic [NLANES-1:0]      dtc_din_we,
    output logic [5:0]             lane_ptr,
    output logic                   busy,
    output logic                   sel_err
);

    typedef enum logic {
        IDLE,
        STROBE
    } state_t;

    localparam logic [6:0]        LANES_W  = 7'(NLANES);
    localparam logic [5:0]        LAST_PTR = 6'(NLANES - 1);
    localparam logic [3:0]        STB_INIT = 4'(STB_LEN - 1);
    localparam logic [NLANES-1:0] ONE_LANE = {{(NLANES-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic [3:0]            w_next_cnt;
    logic [NLANES-1:0]     r_we;
    logic [NLANES-1:0]     w_next_we;
    logic [NLANES-1:0]     w_load;
    logic [NLANES*DW-1:0]  r_din;
    logic [5:0]            r_ptr;
    logic                  r_sel_err;
    logic                  w_err;
    logic                  w_ptr_adv;
    logic [5:0]            w_lane;
    logic                  w_in_range;
    logic                  w_bcast;

    assign w_lane     = s_in.auto_inc ? r_ptr : s_in.dtc_wr_sel;
    assign w_in_range = ({1'b0, w_lane} < LANES_W);

`ifdef DTC_BCAST_EN
    assign w_bcast = !s_in.auto_inc && (s_in.dtc_wr_sel == 6'd63);
`else
    assign w_bcast = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_we    = r_we;
        w_load       = '0;
        w_err        = 1'b0;
        w_ptr_adv    = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_in.din_valid) begin
                    if (w_bcast) begin
                        w_load       = '1;
                        w_next_we    = '1;
                        w_next_cnt   = STB_INIT;
                        w_next_state = STROBE;
                    end else if (w_in_range) begin
                        w_load       = ONE_LANE << w_lane;
                        w_next_we    = ONE_LANE << w_lane;
                        w_next_cnt   = STB_INIT;
                        w_next_state = STROBE;
                        w_ptr_adv    = s_in.auto_inc;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_next_we    = '0;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge dcsclk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_we      <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_we      <= w_next_we;
            r_sel_err <= w_err;
        end
    end

    // NOTE: the lane slices are reset because a mid-strobe reset must visibly discard them.
    always_ff @(posedge dcsclk or posedge reset) begin
        if (reset) begin
            r_din <= '0;
        end else begin
            for (int j = 0; j < NLANES; j++) begin
                if (w_load[j]) begin
                    r_din[j*DW +: DW] <= s_in.din;
                end
            end
        end
    end

    // A synchronous clear wins over an advance on the same edge.
    always_ff @(posedge dcsclk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (ptr_clr) begin
            r_ptr <= '0;
        end else if (w_ptr_adv) begin
            r_ptr <= (r_ptr == LAST_PTR) ? 6'd0 : r_ptr + 6'd1;
        end
    end

    assign s_in.din_ready = (r_state == IDLE);
    assign busy           = (r_state == STROBE);
    assign dtc_din        = r_din;
    assign dtc_din_we     = r_we;
    assign lane_ptr       = r_ptr;
    assign sel_err        = r_sel_err;

endmodule

// File: tb/tb_dtc_lane_distrib.sv
// Directed self-checking bench for dtc_lane_distrib; checks follow the DTC_BCAST_EN build setting.
module tb_dtc_lane_distrib;

    logic         dcsclk = 1'b0;
    logic         reset;
    logic         ptr_clr;
    logic [639:0] dtc_din;
    logic [39:0]  dtc_din_we;
    logic [5:0]   lane_ptr;
    logic         busy;
    logic         sel_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [639:0] exp_din;

    dtc_lane_distrib_if #(.DW(16)) u_if ();

    dtc_lane_distrib #(.NLANES(40), .DW(16), .STB_LEN(2)) u_dut (
        .dcsclk     (dcsclk),
        .reset      (reset),
        .s_in       (u_if),
        .ptr_clr    (ptr_clr),
        .dtc_din    (dtc_din),
        .dtc_din_we (dtc_din_we),
        .lane_ptr   (lane_ptr),
        .busy       (busy),
        .sel_err    (sel_err)
    );

    always #5 dcsclk = ~dcsclk;

    task automatic tick();
        @(posedge dcsclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Presents one word, waits (bounded) for ready, and lets it be accepted on one edge.
    task automatic send(input logic [15:0] d, input logic [5:0] sel, input logic ai);
        int n;
        u_if.din        = d;
        u_if.dtc_wr_sel = sel;
        u_if.auto_inc   = ai;
        u_if.din_valid  = 1'b1;
        n = 0;
        while (!u_if.din_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready_timeout", {639'd0, (n < 20)}, 640'd1);
        tick();
        u_if.din_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        ptr_clr         = 1'b0;
        u_if.din        = '0;
        u_if.din_valid  = 1'b0;
        u_if.dtc_wr_sel = '0;
        u_if.auto_inc   = 1'b0;
        tick();
        tick();
        check("rst_din",   dtc_din, 640'd0);
        check("rst_we",    dtc_din_we, 640'd0);
        check("rst_ptr",   lane_ptr, 640'd0);
        check("rst_ready", u_if.din_ready, 640'd1);
        check("rst_busy",  busy, 640'd0);
        check("rst_err",   sel_err, 640'd0);
        reset = 1'b0;
        tick();

        // 1: single explicit write to lane 5
        u_if.din        = 16'hA5A5;
        u_if.dtc_wr_sel = 6'd5;
        u_if.din_valid  = 1'b1;
        tick();
        u_if.din_valid = 1'b0;
        exp_din = 640'hA5A5 << 80;
        check("t1_din",    dtc_din, exp_din);
        check("t1_we_c0",  dtc_din_we, 640'h20);
        check("t1_rdy_c0", u_if.din_ready, 640'd0);
        check("t1_busy",   busy, 640'd1);
        tick();
        check("t1_we_c1",  dtc_din_we, 640'h20);
        check("t1_rdy_c1", u_if.din_ready, 640'd0);
        tick();
        check("t1_we_end",  dtc_din_we, 640'd0);
        check("t1_rdy_end", u_if.din_ready, 640'd1);

        // 2: back-to-back with valid held; second accept exactly 3 edges later
        u_if.din        = 16'h1111;
        u_if.dtc_wr_sel = 6'd0;
        u_if.din_valid  = 1'b1;
        tick();
        u_if.din        = 16'h2222;
        u_if.dtc_wr_sel = 6'd39;
        exp_din[15:0] = 16'h1111;
        check("t2_we_a",   dtc_din_we, 640'h1);
        check("t2_rdy_a1", u_if.din_ready, 640'd0);
        tick();
        check("t2_rdy_a2", u_if.din_ready, 640'd0);
        tick();
        check("t2_rdy_a3", u_if.din_ready, 640'd1);
        check("t2_pre",    dtc_din, exp_din);
        tick();
        u_if.din_valid = 1'b0;
        exp_din[639:624] = 16'h2222;
        check("t2_din",  dtc_din, exp_din);
        check("t2_we_b", dtc_din_we, 640'h80_0000_0000);
        tick();
        tick();

        // 3: 41 auto-increment writes of k; explicit select is ignored
        for (int k = 0; k <= 40; k++) begin
            check($sformatf("t3_ptr_%0d", k), lane_ptr, 640'(k % 40));
            send(16'(k), 6'd45, 1'b1);
        end
        tick();
        tick();
        check("t3_ptr_final", lane_ptr, 640'd1);
        for (int j = 0; j < 40; j++) exp_din[j*16 +: 16] = 16'(j);
        exp_din[15:0] = 16'd40;
        check("t3_din", dtc_din, exp_din);

        // 4: out-of-range explicit select is dropped
        u_if.din        = 16'h1234;
        u_if.dtc_wr_sel = 6'd45;
        u_if.auto_inc   = 1'b0;
        u_if.din_valid  = 1'b1;
        tick();
        u_if.din_valid = 1'b0;
        check("t4_err_hi", sel_err, 640'd1);
        check("t4_we",     dtc_din_we, 640'd0);
        check("t4_rdy",    u_if.din_ready, 640'd1);
        check("t4_din",    dtc_din, exp_din);
        check("t4_ptr",    lane_ptr, 640'd1);
        tick();
        check("t4_err_lo", sel_err, 640'd0);

        // pointer clear, and clear beating an advance on the same edge
        ptr_clr = 1'b1;
        tick();
        check("clr_ptr", lane_ptr, 640'd0);
        send(16'h7777, 6'd0, 1'b1);
        ptr_clr = 1'b0;
        exp_din[15:0] = 16'h7777;
        check("clr_prio_ptr", lane_ptr, 640'd0);
        check("clr_prio_din", dtc_din, exp_din);
        tick();
        tick();

        // 6: select 63
        u_if.din        = 16'hBEEF;
        u_if.dtc_wr_sel = 6'd63;
        u_if.auto_inc   = 1'b0;
        u_if.din_valid  = 1'b1;
        tick();
        u_if.din_valid = 1'b0;
`ifdef DTC_BCAST_EN
        for (int j = 0; j < 40; j++) exp_din[j*16 +: 16] = 16'hBEEF;
        check("t6_din",   dtc_din, exp_din);
        check("t6_we_c0", dtc_din_we, {600'd0, 40'hFF_FFFF_FFFF});
        check("t6_err",   sel_err, 640'd0);
        tick();
        check("t6_we_c1", dtc_din_we, {600'd0, 40'hFF_FFFF_FFFF});
        tick();
        check("t6_we_end", dtc_din_we, 640'd0);
        check("t6_ptr",    lane_ptr, 640'd0);
`else
        check("t6_err", sel_err, 640'd1);
        check("t6_we",  dtc_din_we, 640'd0);
        check("t6_din", dtc_din, exp_din);
        check("t6_rdy", u_if.din_ready, 640'd1);
        tick();
        check("t6_err_lo", sel_err, 640'd0);
`endif
        tick();

        // 5: reset in the second strobe cycle of a lane-7 write
        send(16'hCAFE, 6'd7, 1'b0);
        check("t5_we_c0", dtc_din_we, 640'h80);
        tick();
        check("t5_we_c1", dtc_din_we, 640'h80);
        #2;
        reset = 1'b1;
        #1;
        check("t5_we",    dtc_din_we, 640'd0);
        check("t5_din",   dtc_din, 640'd0);
        check("t5_ptr",   lane_ptr, 640'd0);
        check("t5_rdy",   u_if.din_ready, 640'd1);
        check("t5_busy",  busy, 640'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
